// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
// Frame state enum, prefix byte values, default timeout and a parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0]  PS2_PREFIX_EXT      = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BRK      = 8'hF0;
  localparam int unsigned PS2_TIMEOUT_DEFAULT = 50000;

  // PS/2 uses odd parity: data plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Event bus from the scan-code receiver to its consumer.
// Handshake: valid is a one-cycle pulse with no ready; outCode/makeBreak/extended
// change only in the cycle valid is high and hold until the next pulse. frame_err
// is an independent one-cycle pulse and never coincides with valid. dbg_state
// mirrors the frame FSM state for observation.
interface ps2_scancode_rx_if;
  import ps2_pkg::*;

  logic         valid;
  logic [7:0]   outCode;
  logic         makeBreak;
  logic         extended;
  logic         frame_err;
  frame_state_e dbg_state;

  modport master (
    output valid, outCode, makeBreak, extended, frame_err, dbg_state
  );

  modport slave (
    input valid, outCode, makeBreak, extended, frame_err, dbg_state
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, frame FSM and
// inactivity timeout. Emits one-cycle byte_ok_o / byte_err_o pulses.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk_i,
  input  logic         ps2_dat_i,
  output logic [7:0]   byte_o,
  output logic         byte_ok_o,
  output logic         byte_err_o,
  output frame_state_e state_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q, dat_smp_q;
  logic fall_q;

  frame_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         par_ok_q, par_ok_d;
  logic [7:0]   byte_q, byte_d;
  logic         byte_ok_q, byte_ok_d;
  logic         byte_err_q, byte_err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // Two-flop synchronizers (reset to idle-high), registered falling edge with aligned data sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      dat_smp_q  <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat_i;
      dat_s2_q   <= dat_s1_q;
      dat_smp_q  <= dat_s2_q;
      fall_q     <= clk_prev_q & ~clk_s2_q;
    end
  end

  // Frame FSM state, shift register, result pulses and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_ok_q   <= 1'b0;
      byte_q     <= '0;
      byte_ok_q  <= 1'b0;
      byte_err_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      byte_q     <= byte_d;
      byte_ok_q  <= byte_ok_d;
      byte_err_q <= byte_err_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state logic: one bit per synchronized falling edge; timeout wins over a stalled frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_ok_d   = par_ok_q;
    byte_d     = byte_q;
    byte_ok_d  = 1'b0;
    byte_err_d = 1'b0;
    tmo_d      = '0;

    if (state_q != IDLE) begin
      tmo_d = fall_q ? '0 : tmo_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (fall_q && !dat_smp_q) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (fall_q) begin
          shift_d = {dat_smp_q, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_q) begin
          par_ok_d = odd_parity_ok(shift_q, dat_smp_q);
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          state_d = IDLE;
          if (dat_smp_q && par_ok_q) begin
            byte_ok_d = 1'b1;
            byte_d    = shift_q;
          end else begin
            byte_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && !fall_q && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
      state_d    = IDLE;
      byte_ok_d  = 1'b0;
      byte_err_d = 1'b1;
      tmo_d      = '0;
    end
  end

  assign byte_o     = byte_q;
  assign byte_ok_o  = byte_ok_q;
  assign byte_err_o = byte_err_q;
  assign state_o    = state_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scan-code receiver top: frame receiver plus prefix decoder
// (E0 = extended, F0 = break) and registered event outputs.
// Optional macro PS2_REPEAT_FILTER_EN suppresses typematic repeat makes.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  PS2_CLK,
  input  logic                  PS2_DAT,
  ps2_scancode_rx_if.master     evt
);

  logic [7:0]   byte_w;
  logic         byte_ok_w;
  logic         byte_err_w;
  frame_state_e state_w;

  logic       ext_flag_q, ext_flag_d;
  logic       brk_flag_q, brk_flag_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic [7:0] code_q, code_d;
  logic       mb_q, mb_d;
  logic       ext_q, ext_d;
  logic       emit;

`ifdef PS2_REPEAT_FILTER_EN
  logic       rep_valid_q, rep_valid_d;
  logic [7:0] rep_code_q, rep_code_d;
  logic       rep_ext_q, rep_ext_d;
`endif

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (CLOCK_50),
    .rst        (reset),
    .ps2_clk_i  (PS2_CLK),
    .ps2_dat_i  (PS2_DAT),
    .byte_o     (byte_w),
    .byte_ok_o  (byte_ok_w),
    .byte_err_o (byte_err_w),
    .state_o    (state_w)
  );

  // Prefix flags and output event registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ext_flag_q <= 1'b0;
      brk_flag_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 8'h00;
      mb_q       <= 1'b0;
      ext_q      <= 1'b0;
    end else begin
      ext_flag_q <= ext_flag_d;
      brk_flag_q <= brk_flag_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      code_q     <= code_d;
      mb_q       <= mb_d;
      ext_q      <= ext_d;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  // Last make event seen, used to drop typematic repeats.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rep_valid_q <= 1'b0;
      rep_code_q  <= 8'h00;
      rep_ext_q   <= 1'b0;
    end else begin
      rep_valid_q <= rep_valid_d;
      rep_code_q  <= rep_code_d;
      rep_ext_q   <= rep_ext_d;
    end
  end
`endif

  // Decode each good byte: prefixes only set flags, any other byte is an event.
  always_comb begin
    ext_flag_d = ext_flag_q;
    brk_flag_d = brk_flag_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;
    mb_d       = mb_q;
    ext_d      = ext_q;
    emit       = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
    rep_valid_d = rep_valid_q;
    rep_code_d  = rep_code_q;
    rep_ext_d   = rep_ext_q;
`endif

    if (byte_err_w) begin
      err_d      = 1'b1;
      ext_flag_d = 1'b0;
      brk_flag_d = 1'b0;
    end else if (byte_ok_w) begin
      if (byte_w == PS2_PREFIX_EXT) begin
        ext_flag_d = 1'b1;
      end else if (byte_w == PS2_PREFIX_BRK) begin
        brk_flag_d = 1'b1;
      end else begin
        ext_flag_d = 1'b0;
        brk_flag_d = 1'b0;
        emit       = 1'b1;
`ifdef PS2_REPEAT_FILTER_EN
        if (!brk_flag_q) begin
          if (rep_valid_q && (rep_code_q == byte_w) && (rep_ext_q == ext_flag_q)) emit = 1'b0;
          rep_valid_d = 1'b1;
          rep_code_d  = byte_w;
          rep_ext_d   = ext_flag_q;
        end else if (rep_valid_q && (rep_code_q == byte_w) && (rep_ext_q == ext_flag_q)) begin
          rep_valid_d = 1'b0;
        end
`endif
        if (emit) begin
          valid_d = 1'b1;
          code_d  = byte_w;
          mb_d    = ~brk_flag_q;
          ext_d   = ext_flag_q;
        end
      end
    end
  end

  assign evt.valid     = valid_q;
  assign evt.frame_err = err_q;
  assign evt.outCode   = code_q;
  assign evt.makeBreak = mb_q;
  assign evt.extended  = ext_q;
  assign evt.dbg_state = state_w;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-banged PS/2 frames, expected events
// queued before each frame and matched against valid pulses by a monitor.
module tb_ps2_scancode_rx;
  import ps2_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_dat;

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_scancode_rx_if evt ();

  ps2_scancode_rx dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat),
    .evt      (evt)
  );

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  int pass_cnt  = 0;
  int chk_cnt   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int stop_cyc  = 0;
  int valid_cyc = 0;
  int err_cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Monitor: pop one expected {makeBreak, extended, code} per valid pulse.
  always @(negedge clk) begin
    logic [9:0] e;
    logic       have;
    if (evt.valid || evt.frame_err)
      check("valid_err_exclusive", {31'b0, evt.valid & evt.frame_err}, 32'd0);
    if (evt.valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      have = (exp_q.size() > 0);
      check("valid_expected", {31'b0, have}, 32'd1);
      if (have) begin
        e = exp_q.pop_front();
        check("event", {22'b0, evt.makeBreak, evt.extended, evt.outCode}, {22'b0, e});
      end
    end
    if (evt.frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_edge(input logic b, input bit mark_stop);
    ps2_dat = b;
    wait_cyc(5);
    ps2_clk = 1'b0;
    if (mark_stop) stop_cyc = cyc;
    wait_cyc(10);
    ps2_clk = 1'b1;
    wait_cyc(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop_val);
    logic par;
    par = ~(^b) ^ flip_par;
    ps2_edge(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_edge(b[i], 1'b0);
    ps2_edge(par, 1'b0);
    ps2_edge(stop_val, 1'b1);
    ps2_dat = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic mb, input logic ext);
    exp_q.push_back({mb, ext, code});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int v0;
    int e0;
    logic [7:0] partial;
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(3);
    check("rst_valid",     {31'b0, evt.valid},     32'd0);
    check("rst_frame_err", {31'b0, evt.frame_err}, 32'd0);
    check("rst_outCode",   {24'b0, evt.outCode},   32'h00);
    check("rst_makeBreak", {31'b0, evt.makeBreak}, 32'd0);
    check("rst_extended",  {31'b0, evt.extended},  32'd0);
    check("rst_state",     {30'b0, evt.dbg_state}, {30'b0, IDLE});
    reset = 1'b0;
    wait_cyc(3);

    // Plain make of 0x1C, with latency measured from the stop-bit clock fall.
    v0 = valid_cnt; e0 = err_cnt;
    expect_evt(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C);
    check("t1_valid_count", valid_cnt - v0, 32'd1);
    check("t1_no_err",      err_cnt - e0,   32'd0);
    check("t1_latency",     valid_cyc - stop_cyc, 32'd5);
    check("t1_hold_code",   {24'b0, evt.outCode}, 32'h1C);

    // Break: F0 1C.
    v0 = valid_cnt;
    expect_evt(8'h1C, 1'b0, 1'b0);
    send_byte(8'hF0);
    check("t2_no_valid_on_f0", valid_cnt - v0, 32'd0);
    send_byte(8'h1C);
    check("t2_valid_count", valid_cnt - v0, 32'd1);

    // Extended make then extended break: E0 75, E0 F0 75.
    v0 = valid_cnt;
    expect_evt(8'h75, 1'b1, 1'b1);
    expect_evt(8'h75, 1'b0, 1'b1);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("t3_valid_count", valid_cnt - v0, 32'd2);

    // Reversed prefix order: F0 E0 6B is an extended break.
    v0 = valid_cnt;
    expect_evt(8'h6B, 1'b0, 1'b1);
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h6B);
    check("t3b_valid_count", valid_cnt - v0, 32'd1);

    // Parity error, then a good frame.
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    check("t4_par_err",     err_cnt - e0,   32'd1);
    check("t4_par_novalid", valid_cnt - v0, 32'd0);
    check("t4_err_latency", err_cyc - stop_cyc, 32'd5);
    expect_evt(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C);
    check("t4_valid_after", valid_cnt - v0, 32'd1);

    // Stop-bit error; a pending break prefix is dropped with it.
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t4b_stop_err",     err_cnt - e0,   32'd1);
    check("t4b_stop_novalid", valid_cnt - v0, 32'd0);
    expect_evt(8'h1C, 1'b0, 1'b0);
    send_byte(8'hF0); send_byte(8'h1C);
    check("t4b_break_after", valid_cnt - v0, 32'd1);

    // Timeout: start + 3 data bits, then the keyboard clock stalls.
    v0 = valid_cnt; e0 = err_cnt;
    partial = 8'h1C;
    ps2_edge(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_edge(partial[i], 1'b0);
    wait_cyc(50001);
    check("t5_timeout_err",   err_cnt - e0,   32'd1);
    check("t5_timeout_novld", valid_cnt - v0, 32'd0);
    check("t5_state_idle",    {30'b0, evt.dbg_state}, {30'b0, IDLE});
    expect_evt(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C);
    check("t5_valid_after", valid_cnt - v0, 32'd1);
    check("t5_one_err",     err_cnt - e0,   32'd1);

    // Reset in the middle of a frame.
    v0 = valid_cnt; e0 = err_cnt;
    ps2_edge(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_edge(partial[i], 1'b0);
    reset = 1'b1;
    wait_cyc(1);
    check("t6_rst_outCode",   {24'b0, evt.outCode},   32'h00);
    check("t6_rst_makeBreak", {31'b0, evt.makeBreak}, 32'd0);
    check("t6_rst_extended",  {31'b0, evt.extended},  32'd0);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(30);
    check("t6_no_valid",  valid_cnt - v0, 32'd0);
    check("t6_no_err",    err_cnt - e0,   32'd0);
    check("t6_state",     {30'b0, evt.dbg_state}, {30'b0, IDLE});
    check("t6_code_zero", {24'b0, evt.outCode},   32'h00);

    // Typematic repeats: 1C 1C 1C F0 1C.
    v0 = valid_cnt;
`ifdef PS2_REPEAT_FILTER_EN
    expect_evt(8'h1C, 1'b1, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b0);
`else
    expect_evt(8'h1C, 1'b1, 1'b0);
    expect_evt(8'h1C, 1'b1, 1'b0);
    expect_evt(8'h1C, 1'b1, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b0);
`endif
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
`ifdef PS2_REPEAT_FILTER_EN
    check("t7_valid_count", valid_cnt - v0, 32'd2);
`else
    check("t7_valid_count", valid_cnt - v0, 32'd4);
`endif

    wait_cyc(10);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
